// File: rtl/relay_framer.sv
// Relay frame tracker: samples the decoded relay stream on a divided tick, matches
// run-time start/end patterns and drives mod_type, tx_gate and frame-length reporting.
module relay_framer #(
   parameter int DIV_BITS  = 4,
   parameter int DIV_MATCH = 8,
   parameter int BUF_W     = 20,
   parameter int DATA_TAP  = 3,
   parameter int LEN_W     = 10,
   parameter int MAX_FRAME = 1023
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       mode_sel,
   input  logic             din,
   input  logic [BUF_W-1:0] start_pat,
   input  logic [BUF_W-1:0] start_mask,
   input  logic [BUF_W-1:0] end_pat,
   input  logic [BUF_W-1:0] end_mask,
   output logic [2:0]       mod_type,
   output logic             data_out,
   output logic             tx_gate,
   output logic             frame_done,
   output logic             timeout,
   output logic [LEN_W-1:0] frame_len
);

   localparam logic [2:0] MODE_READER = 3'b101;
   localparam logic [2:0] MODE_TAG    = 3'b110;

   typedef enum logic [1:0] {ST_IDLE, ST_LISTEN, ST_MOD} state_t;

   state_t              state;
   logic [DIV_BITS-1:0] div;
   logic [BUF_W-1:0]    shift_buf;
   logic [2:0]          phase;
   logic [LEN_W-1:0]    len;
   logic [2:0]          mode_q;

   logic                tick;
   logic                mode_chg;
   logic                mode_ok;
   logic                sel_ok;
   logic [BUF_W-1:0]    buf_n;
   logic [2:0]          phase_n;
   logic [LEN_W-1:0]    len_n;
   logic                start_hit;
   logic                end_hit;

   function automatic logic [2:0] listen_code(input logic [2:0] mode);
      return (mode == MODE_READER) ? 3'b011 : (mode == MODE_TAG) ? 3'b001 : 3'b000;
   endfunction

   function automatic logic [2:0] mod_code(input logic [2:0] mode);
      return (mode == MODE_READER) ? 3'b100 : (mode == MODE_TAG) ? 3'b010 : 3'b000;
   endfunction

   assign tick      = (div == DIV_BITS'(DIV_MATCH));
   assign mode_chg  = (mode_sel != mode_q);
   assign mode_ok   = (mode_q == MODE_READER) || (mode_q == MODE_TAG);
   assign sel_ok    = (mode_sel == MODE_READER) || (mode_sel == MODE_TAG);
   assign buf_n     = {shift_buf[BUF_W-2:0], din};
   assign phase_n   = phase + 3'd1;
   assign len_n     = len + LEN_W'(1);
   assign start_hit = ((buf_n ^ start_pat) & start_mask) == '0;
   assign end_hit   = ((buf_n ^ end_pat) & end_mask) == '0;
   assign data_out  = shift_buf[DATA_TAP];

   // NOTE: all state is updated with non-blocking assignments so every branch below
   // reads pre-edge values; blocking here would let earlier lines leak into later ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         div        <= '0;
         shift_buf  <= '0;
         phase      <= '0;
         len        <= '0;
         mode_q     <= '0;
         mod_type   <= 3'b000;
         tx_gate    <= 1'b1;
         frame_done <= 1'b0;
         timeout    <= 1'b0;
         frame_len  <= '0;
      end else begin
         div        <= div + DIV_BITS'(1);
         mode_q     <= mode_sel;
         frame_done <= 1'b0;
         timeout    <= 1'b0;
         // A mode change abandons any frame in flight and overrides the tick.
         if (mode_chg) begin
            shift_buf <= '0;
            phase     <= '0;
            len       <= '0;
            tx_gate   <= 1'b1;
            state     <= sel_ok ? ST_LISTEN : ST_IDLE;
            mod_type  <= listen_code(mode_sel);
         end else if (tick) begin
            if (!mode_ok) begin
               state     <= ST_IDLE;
               mod_type  <= 3'b000;
               tx_gate   <= 1'b1;
               shift_buf <= '0;
            end else begin
               shift_buf <= buf_n;
               phase     <= phase_n;
               case (state)
                  ST_IDLE: begin
                     state    <= ST_LISTEN;
                     mod_type <= listen_code(mode_q);
                  end
                  ST_LISTEN: begin
                     if (start_hit) begin
                        state    <= ST_MOD;
                        phase    <= '0;
                        len      <= '0;
                        mod_type <= mod_code(mode_q);
                        tx_gate  <= 1'b0;
                     end
                  end
                  ST_MOD: begin
                     // End match takes precedence over the length limit on the same tick.
                     if (end_hit && phase_n == 3'd0) begin
                        state      <= ST_LISTEN;
                        frame_len  <= len_n;
                        frame_done <= 1'b1;
                        mod_type   <= listen_code(mode_q);
                        tx_gate    <= 1'b1;
                     end else if (len_n == LEN_W'(MAX_FRAME)) begin
                        state     <= ST_LISTEN;
                        frame_len <= LEN_W'(MAX_FRAME);
                        timeout   <= 1'b1;
                        mod_type  <= listen_code(mode_q);
                        tx_gate   <= 1'b1;
                     end else begin
                        len <= len_n;
                     end
                  end
                  default: begin
                     state    <= ST_IDLE;
                     mod_type <= 3'b000;
                     tx_gate  <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_relay_framer.sv
// Directed bench for relay_framer: listen, start, end, timeout, mode switch and reset.
module tb_relay_framer;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  mode_sel;
   logic        din;
   logic [19:0] start_pat, start_mask, end_pat, end_mask;
   logic [2:0]  mod_type;
   logic        data_out, tx_gate, frame_done, timeout;
   logic [9:0]  frame_len;

   int          tests  = 0;
   int          failed = 0;
   logic [3:0]  div_m  = 4'd0;

   relay_framer #(.MAX_FRAME(64)) dut (
      .clk(clk), .reset(reset), .mode_sel(mode_sel), .din(din),
      .start_pat(start_pat), .start_mask(start_mask),
      .end_pat(end_pat), .end_mask(end_mask),
      .mod_type(mod_type), .data_out(data_out), .tx_gate(tx_gate),
      .frame_done(frame_done), .timeout(timeout), .frame_len(frame_len)
   );

   always #5 clk = ~clk;

   // Every clock edge the bench waits on passes through here, keeping the divider model in step.
   task automatic clk_step(output bit was_tick);
      @(posedge clk);
      was_tick = (div_m == 4'd8);
      div_m    = div_m + 4'd1;
   endtask

   task automatic tick_bit(input logic d);
      bit t = 1'b0;
      din = d;
      for (int i = 0; i < 40 && !t; i++) clk_step(t);
      if (!t) begin
         tests++; failed++;
         $display("FAIL tick_wait: no tick within 40 clk");
      end
      #1;
   endtask

   task automatic test_reset;
      bit t;
      reset = 1'b1; mode_sel = 3'b000; din = 1'b0;
      start_pat = 20'h0000C; start_mask = 20'hFFFFF;
      end_pat   = 20'h00000; end_mask   = 20'hFFFFF;
      clk_step(t); #1;
      tests++;
      if ({mod_type, tx_gate, data_out, frame_done, timeout} !== 7'b000_1_0_0_0 || frame_len !== 10'd0) begin
         failed++;
         $display("FAIL reset_state: mod=%b gate=%b dout=%b done=%b to=%b len=%0d want 000/1/0/0/0/0",
                  mod_type, tx_gate, data_out, frame_done, timeout, frame_len);
      end
      reset = 1'b0; div_m = 4'd0;
   endtask

   task automatic test_listen;
      mode_sel = 3'b101;
      tick_bit(1'b0);
      tests++;
      if (mod_type !== 3'b011 || tx_gate !== 1'b1) begin
         failed++; $display("FAIL reader_listen: mod=%b gate=%b want 011/1", mod_type, tx_gate);
      end
      tests++;
      if (frame_done !== 1'b0 || timeout !== 1'b0) begin
         failed++; $display("FAIL listen_pulses: done=%b to=%b want 0/0", frame_done, timeout);
      end
   endtask

   task automatic test_start;
      for (int i = 0; i < 16; i++) tick_bit(1'b0);
      tick_bit(1'b1); tick_bit(1'b1); tick_bit(1'b0);
      tests++;
      if (mod_type !== 3'b011) begin
         failed++; $display("FAIL start_early: mod=%b want 011", mod_type);
      end
      tick_bit(1'b0);
      tests++;
      if (mod_type !== 3'b100 || tx_gate !== 1'b0 || data_out !== 1'b1) begin
         failed++;
         $display("FAIL reader_mod: mod=%b gate=%b dout=%b want 100/0/1", mod_type, tx_gate, data_out);
      end
   endtask

   task automatic test_end;
      bit seen = 1'b0;
      bit t;
      for (int i = 0; i < 23; i++) begin
         tick_bit(1'b0);
         if (frame_done || timeout || mod_type !== 3'b100) seen = 1'b1;
      end
      tests++;
      if (seen) begin
         failed++; $display("FAIL end_early: frame left MOD before tick 24 (got exit, want none)");
      end
      tick_bit(1'b0);
      tests++;
      if (frame_done !== 1'b1 || timeout !== 1'b0 || frame_len !== 10'd24) begin
         failed++;
         $display("FAIL end_exit: done=%b to=%b len=%0d want 1/0/24", frame_done, timeout, frame_len);
      end
      tests++;
      if (mod_type !== 3'b011 || tx_gate !== 1'b1 || data_out !== 1'b0) begin
         failed++;
         $display("FAIL end_state: mod=%b gate=%b dout=%b want 011/1/0", mod_type, tx_gate, data_out);
      end
      clk_step(t); #1;
      tests++;
      if (frame_done !== 1'b0) begin
         failed++; $display("FAIL done_width: done=%b want 0", frame_done);
      end
   endtask

   task automatic test_timeout;
      bit seen = 1'b0;
      bit t;
      tick_bit(1'b1); tick_bit(1'b1); tick_bit(1'b0); tick_bit(1'b0);
      tests++;
      if (mod_type !== 3'b100) begin
         failed++; $display("FAIL to_start: mod=%b want 100", mod_type);
      end
      for (int i = 0; i < 63; i++) begin
         tick_bit((i % 2 == 0) ? 1'b1 : 1'b0);
         if (frame_done || timeout || mod_type !== 3'b100) seen = 1'b1;
      end
      tests++;
      if (seen) begin
         failed++; $display("FAIL to_early: frame left MOD before tick 64 (got exit, want none)");
      end
      tick_bit(1'b0);
      tests++;
      if (timeout !== 1'b1 || frame_done !== 1'b0 || frame_len !== 10'd64 || mod_type !== 3'b011) begin
         failed++;
         $display("FAIL to_exit: to=%b done=%b len=%0d mod=%b want 1/0/64/011",
                  timeout, frame_done, frame_len, mod_type);
      end
      clk_step(t); #1;
      tests++;
      if (timeout !== 1'b0) begin
         failed++; $display("FAIL to_width: to=%b want 0", timeout);
      end
   endtask

   task automatic test_mode_switch;
      bit seen = 1'b0;
      bit t;
      for (int i = 0; i < 16; i++) tick_bit(1'b0);
      tick_bit(1'b1); tick_bit(1'b1); tick_bit(1'b0); tick_bit(1'b0);
      tick_bit(1'b0); tick_bit(1'b0); tick_bit(1'b0);
      tests++;
      if (mod_type !== 3'b100) begin
         failed++; $display("FAIL sw_premod: mod=%b want 100", mod_type);
      end
      mode_sel = 3'b110;
      clk_step(t); #1;
      tests++;
      if (mod_type !== 3'b001 || tx_gate !== 1'b1 || data_out !== 1'b0 || frame_len !== 10'd64) begin
         failed++;
         $display("FAIL sw_listen: mod=%b gate=%b dout=%b len=%0d want 001/1/0/64",
                  mod_type, tx_gate, data_out, frame_len);
      end
      tests++;
      if (frame_done !== 1'b0 || timeout !== 1'b0) begin
         failed++; $display("FAIL sw_pulses: done=%b to=%b want 0/0", frame_done, timeout);
      end
      start_pat = 20'h000F0;
      for (int i = 0; i < 7; i++) begin
         tick_bit((i < 4) ? 1'b1 : 1'b0);
         if (frame_done || timeout || mod_type !== 3'b001) seen = 1'b1;
      end
      tests++;
      if (seen) begin
         failed++; $display("FAIL tag_early: left tag listen before pattern complete");
      end
      tick_bit(1'b0);
      tests++;
      if (mod_type !== 3'b010 || tx_gate !== 1'b0) begin
         failed++; $display("FAIL tag_mod: mod=%b gate=%b want 010/0", mod_type, tx_gate);
      end
   endtask

   task automatic test_reset_mid;
      bit t;
      for (int i = 0; i < 4; i++) tick_bit(1'b1);
      tests++;
      if (data_out !== 1'b1) begin
         failed++; $display("FAIL pre_reset_dout: dout=%b want 1", data_out);
      end
      reset = 1'b1;
      #1;
      tests++;
      if (mod_type !== 3'b000 || tx_gate !== 1'b1 || data_out !== 1'b0 || frame_len !== 10'd0) begin
         failed++;
         $display("FAIL reset_mid: mod=%b gate=%b dout=%b len=%0d want 000/1/0/0",
                  mod_type, tx_gate, data_out, frame_len);
      end
      clk_step(t); #1;
      reset = 1'b0; div_m = 4'd0;
   endtask

   task automatic test_invalid_mode;
      bit t;
      mode_sel = 3'b111;
      for (int i = 0; i < 4; i++) tick_bit(1'b1);
      tests++;
      if (mod_type !== 3'b000 || tx_gate !== 1'b1 || data_out !== 1'b0) begin
         failed++;
         $display("FAIL invalid_idle: mod=%b gate=%b dout=%b want 000/1/0", mod_type, tx_gate, data_out);
      end
      mode_sel = 3'b110;
      clk_step(t); #1;
      tests++;
      if (mod_type !== 3'b001) begin
         failed++; $display("FAIL invalid_to_tag: mod=%b want 001", mod_type);
      end
   endtask

   initial begin
      test_reset();
      test_listen();
      test_start();
      test_end();
      test_timeout();
      test_mode_switch();
      test_reset_mid();
      test_invalid_mode();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
